// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Bundled global clock / active-low synchronous reset for the
//            memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if;
    logic clk;
    logic rst;

    modport sink   (input  clk, input  rst);
    modport source (output clk, output rst);
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin sharing of one memory request port between N_REQ
//            requesters (port 0 = instruction fetch), one access in flight.
//            Optional macro IFETCH_PRIORITY_EN gives port 0 absolute priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int N_REQ = 3,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    mem_port_arbiter_if.sink        System,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*AW-1:0]     req_addr,
    input  logic [N_REQ*DW-1:0]     req_wdata,
    input  logic [N_REQ-1:0]        req_we,
    output logic [N_REQ-1:0]        req_grant,
    output logic [N_REQ-1:0]        resp_valid,
    output logic [DW-1:0]           resp_rdata,
    input  logic                    flush,
    output logic                    mem_req,
    output logic [AW-1:0]           mem_addr,
    output logic [DW-1:0]           mem_wdata,
    output logic                    mem_we,
    input  logic                    mem_ready,
    input  logic [DW-1:0]           mem_rdata,
    output logic                    busy
);

    localparam int               c_IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [0:0]       c_ST_IDLE = 1'b0;
    localparam logic [0:0]       c_ST_BUSY = 1'b1;
    localparam logic [N_REQ-1:0] c_ONE     = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [c_IW-1:0]  c_LAST    = c_IW'(N_REQ - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [c_IW-1:0]  r_rr_ptr;
    logic [c_IW-1:0]  r_owner;
    logic             r_drop;
    logic [N_REQ-1:0] r_grant;
    logic [N_REQ-1:0] r_resp_valid;
    logic [DW-1:0]    r_resp_rdata;
    logic [AW-1:0]    r_mem_addr;
    logic [DW-1:0]    r_mem_wdata;
    logic             r_mem_we;

    logic             w_any;
    logic [c_IW-1:0]  w_winner;
    logic             w_done;
    logic             w_flush_fetch;
    logic [c_IW-1:0]  w_rr_next;

    function automatic logic [c_IW-1:0] wrap_idx(input int v);
        return c_IW'((v >= N_REQ) ? v - N_REQ : v);
    endfunction

    // Rotating scan starting at r_rr_ptr; first requester found wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
`ifdef IFETCH_PRIORITY_EN
        if (req_valid[0]) begin
            w_any    = 1'b1;
            w_winner = '0;
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_any && (wrap_idx(int'(r_rr_ptr) + i) != '0)
                    && req_valid[wrap_idx(int'(r_rr_ptr) + i)]) begin
                w_any    = 1'b1;
                w_winner = wrap_idx(int'(r_rr_ptr) + i);
            end
        end
`else
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_any && req_valid[wrap_idx(int'(r_rr_ptr) + i)]) begin
                w_any    = 1'b1;
                w_winner = wrap_idx(int'(r_rr_ptr) + i);
            end
        end
`endif
    end

    // Pointer advance after completion; fetch never moves it in priority mode.
    always_comb begin
`ifdef IFETCH_PRIORITY_EN
        if (r_owner == '0)
            w_rr_next = r_rr_ptr;
        else if (r_owner == c_LAST)
            w_rr_next = c_IW'(1);
        else
            w_rr_next = r_owner + c_IW'(1);
`else
        if (r_owner == c_LAST)
            w_rr_next = '0;
        else
            w_rr_next = r_owner + c_IW'(1);
`endif
    end

    assign w_done        = (r_state == c_ST_BUSY) && mem_ready;
    assign w_flush_fetch = (r_state == c_ST_BUSY) && flush && (r_owner == '0);

    always_ff @(posedge System.clk) begin
        if (!System.rst)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (w_any)     w_state_nxt = c_ST_BUSY;
            c_ST_BUSY: if (mem_ready) w_state_nxt = c_ST_IDLE;
            default:                  w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req = (r_state == c_ST_BUSY);
        busy    = (r_state == c_ST_BUSY);
    end

    always_ff @(posedge System.clk) begin
        if (!System.rst) begin
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_drop       <= 1'b0;
            r_grant      <= '0;
            r_resp_valid <= '0;
            r_resp_rdata <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
        end else begin
            r_grant      <= '0;
            r_resp_valid <= '0;
            if ((r_state == c_ST_IDLE) && w_any) begin
                r_owner     <= w_winner;
                r_mem_addr  <= req_addr[int'(w_winner)*AW +: AW];
                r_mem_wdata <= req_wdata[int'(w_winner)*DW +: DW];
                r_mem_we    <= req_we[w_winner];
                r_grant     <= c_ONE << w_winner;
            end
            if (w_flush_fetch)
                r_drop <= 1'b1;
            // A flush landing on the completion cycle still kills the fetch.
            if (w_done) begin
                r_resp_rdata <= mem_rdata;
                if (!(r_drop || w_flush_fetch))
                    r_resp_valid <= c_ONE << r_owner;
                r_drop   <= 1'b0;
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    assign req_grant  = r_grant;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_we     = r_mem_we;

endmodule

`default_nettype wire
